sync_fifo_flags: RTL

Parametrised single-clock FIFO with full-depth occupancy, a live count, programmable almost-full/almost-empty thresholds and overflow/underflow error pulses. Every slot of DEPTH is usable. It is the general-purpose buffering primitive between producer and consumer stages in the same clock domain. An optional first-word-fall-through read mode is selected at compile time.

---
 rtl/sync_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_mem.sv | 53 +++++
 rtl/sync_fifo_flags.sv | 108 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Purpose : shared types and elaboration helpers for the sync_fifo_flags slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   ptr_w(depth)  - pointer width: address bits plus one wrap bit
//   is_pow2(v)    - true when v is a non-zero power of two
//   fifo_err_t    - registered error pulses {overflow, underflow}
package sync_fifo_pkg;

   // One extra bit beyond the address lets full and empty be told apart
   // when the address bits of both pointers coincide.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Purpose : dual-port storage array, one synchronous write port, one read port.
// Latency : write lands at the clock edge; read is 1 cycle (registered) or 0 (FWFT).
// Backpressure: none; the caller only asserts we/re for accepted operations.
//
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset (read register only)
//   we, waddr, wdata   - write port
//   re, raddr, rdata   - read port
// Build option: SYNC_FIFO_FWFT_EN makes the read port combinational.
module sync_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Storage is deliberately not reset; contents are only ever observed
   // through a pointer that has been written since reset.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented continuously; the pop only advances raddr
   // in the parent, so neither re nor rst_n is needed here.
   assign rdata = mem[raddr];

   logic unused_rd_ctrl;
   assign unused_rd_ctrl = &{1'b0, re, rst_n};
`else
   // Output register holds its value whenever no read is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Purpose : single-clock FIFO with count, almost-full/empty flags and error pulses.
// Latency : flags update the cycle after an accepting edge; data_out 1 cycle after r_en (0 in FWFT).
// Backpressure: writes while full / reads while empty are dropped and flagged one cycle later.
//
// Ports:
//   clk, rst_n               - clock, synchronous active-low reset
//   w_en, data_in            - write request and data
//   r_en, data_out           - read request (pop in FWFT) and data
//   full, empty              - occupancy == DEPTH / == 0
//   almost_full/almost_empty - count >= AF_LEVEL / count <= AE_LEVEL
//   count                    - occupancy 0..DEPTH
//   overflow, underflow      - one-cycle pulses for rejected requests
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      w_en,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      r_en,
   output logic [WIDTH-1:0]          data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [ptr_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   generate
      if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
         $error("sync_fifo_flags: DEPTH must be a power of two and at least 2");
      end
      if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
         $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
      end
   endgenerate

   logic [PW-1:0] w_ptr;
   logic [PW-1:0] r_ptr;
   fifo_err_t     err_q;
   logic          wr_acc;
   logic          rd_acc;

   // Flags are pure functions of the pointers, so they reflect the state
   // at the start of the cycle and any accept decision uses that state.
   assign full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
   assign empty = (w_ptr == r_ptr);
   // Modular subtraction stays correct across the wrap bit.
   assign count        = w_ptr - r_ptr;
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);

   // At full, a concurrent read does not free a slot for this cycle's write;
   // at empty, a concurrent write is not bypassed to the reader.
   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_ptr <= '0;
         r_ptr <= '0;
         err_q <= '0;
      end else begin
         if (wr_acc) begin
            w_ptr <= w_ptr + 1'b1;
         end
         if (rd_acc) begin
            r_ptr <= r_ptr + 1'b1;
         end
         err_q.overflow  <= w_en && full;
         err_q.underflow <= r_en && empty;
      end
   end

   assign overflow  = err_q.overflow;
   assign underflow = err_q.underflow;

   // Write is suppressed during reset so a request in the reset cycle
   // leaves no trace in the array.
   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc && rst_n),
      .waddr (w_ptr[AW-1:0]),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (r_ptr[AW-1:0]),
      .rdata (data_out)
   );

endmodule
